// File: rtl/display_pkg.sv
// Shared 640x480@60 raster timing, glyph geometry and colour type for the glyph scanout block.
package display_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int GLYPH_W    = 3;
    localparam int GLYPH_H    = 5;
    localparam int CELLS_W    = 7;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
    localparam int FB_BITS    = 2 * GLYPH_BITS;

    typedef logic [11:0]        colour_t;
    typedef logic [9:0]         hcount_t;
    typedef logic [9:0]         vcount_t;
    typedef logic [FB_BITS-1:0] framebuffer_t;

    // Glyph bits are row-major from the top row, MSB first within each row.
    function automatic logic [GLYPH_W-1:0] glyph_row(input logic [GLYPH_BITS-1:0] glyph,
                                                     input logic [2:0]            row);
        case (row)
            3'd0:    glyph_row = glyph[14:12];
            3'd1:    glyph_row = glyph[11:9];
            3'd2:    glyph_row = glyph[8:6];
            3'd3:    glyph_row = glyph[5:3];
            default: glyph_row = glyph[2:0];
        endcase
    endfunction

endpackage

// File: rtl/glyph_scanout_if.sv
// Framebuffer load port and VGA output bundle of the glyph scanout block.
interface glyph_scanout_if;

    logic [29:0] framebuffer;
    logic        load;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    modport master (
        output framebuffer, load,
        input  hsync, vsync, vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        input  framebuffer, load,
        output hsync, vsync, vga_r, vga_g, vga_b, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster counters with registered active-low syncs and a visible-area flag.
module vga_timing
    import display_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    output hcount_t h_cnt,
    output vcount_t v_cnt,
    output logic    line_end,
    output logic    frame_end,
    output logic    visible,
    output logic    hsync,
    output logic    vsync
);

    localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
    localparam vcount_t V_LAST   = vcount_t'(V_TOTAL - 1);
    localparam hcount_t H_VIS    = hcount_t'(H_VISIBLE);
    localparam vcount_t V_VIS    = vcount_t'(V_VISIBLE);
    localparam hcount_t HS_FIRST = hcount_t'(H_VISIBLE + H_FRONT);
    localparam hcount_t HS_LAST  = hcount_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam vcount_t VS_FIRST = vcount_t'(V_VISIBLE + V_FRONT);
    localparam vcount_t VS_LAST  = vcount_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            // Syncs reflect the counter state of this cycle, one clock later.
            hsync <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
            vsync <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        end
    end

endmodule

// File: rtl/glyph_scanout.sv
// Two 3x5 glyphs scaled onto a 640x480 VGA raster from a double-buffered framebuffer.
// Define GLYPH_SCANOUT_BORDER_EN to add a 1-pixel FG border around the glyph area.
module glyph_scanout
    import display_pkg::*;
#(
    parameter int      SCALE = 16,
    parameter int      X0    = 264,
    parameter int      Y0    = 200,
    parameter colour_t FG    = 12'hFFF,
    parameter colour_t BG    = 12'h000
) (
    input  logic           clock,
    input  logic           reset_n,
    glyph_scanout_if.slave bus
);

    typedef logic [4:0] sub_t;
    typedef logic [2:0] cell_t;

    localparam sub_t    SUB_LAST    = sub_t'(SCALE - 1);
    localparam cell_t   X_CELL_LAST = cell_t'(CELLS_W - 1);
    localparam cell_t   Y_CELL_LAST = cell_t'(GLYPH_H - 1);
    localparam hcount_t X_PRE       = (X0 == 0) ? hcount_t'(H_TOTAL - 1) : hcount_t'(X0 - 1);
    localparam vcount_t Y_PRE       = (Y0 == 0) ? vcount_t'(V_TOTAL - 1) : vcount_t'(Y0 - 1);
    localparam vcount_t V_COPY      = vcount_t'(V_VISIBLE);

    hcount_t h_cnt;
    vcount_t v_cnt;
    logic    line_end;
    logic    frame_end;
    logic    visible;
    logic    hsync;
    logic    vsync;

    vga_timing u_timing (
        .clock     (clock),
        .reset_n   (reset_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_end  (line_end),
        .frame_end (frame_end),
        .visible   (visible),
        .hsync     (hsync),
        .vsync     (vsync)
    );

    framebuffer_t pending;
    framebuffer_t active;
    logic         copy;

    assign copy = (h_cnt == '0) && (v_cnt == V_COPY);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (bus.load) begin
                pending <= bus.framebuffer;
            end
            // A load on the copy cycle bypasses pending so it is not lost for a frame.
            if (copy) begin
                active <= bus.load ? bus.framebuffer : pending;
            end
        end
    end

    logic  x_act;
    sub_t  x_sub;
    cell_t x_cell;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_act  <= (X0 == 0);
            x_sub  <= '0;
            x_cell <= '0;
        end else if (h_cnt == X_PRE) begin
            x_act  <= 1'b1;
            x_sub  <= '0;
            x_cell <= '0;
        end else if (line_end) begin
            // Area running past the right edge stops here instead of wrapping.
            x_act <= 1'b0;
        end else if (x_act) begin
            if (x_sub == SUB_LAST) begin
                x_sub <= '0;
                if (x_cell == X_CELL_LAST) begin
                    x_act <= 1'b0;
                end else begin
                    x_cell <= x_cell + 1'b1;
                end
            end else begin
                x_sub <= x_sub + 1'b1;
            end
        end
    end

    logic  y_act;
    sub_t  y_sub;
    cell_t y_cell;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_act  <= (Y0 == 0);
            y_sub  <= '0;
            y_cell <= '0;
        end else if (line_end) begin
            if (v_cnt == Y_PRE) begin
                y_act  <= 1'b1;
                y_sub  <= '0;
                y_cell <= '0;
            end else if (frame_end) begin
                y_act <= 1'b0;
            end else if (y_act) begin
                if (y_sub == SUB_LAST) begin
                    y_sub <= '0;
                    if (y_cell == Y_CELL_LAST) begin
                        y_act <= 1'b0;
                    end else begin
                        y_cell <= y_cell + 1'b1;
                    end
                end else begin
                    y_sub <= y_sub + 1'b1;
                end
            end
        end
    end

    logic [GLYPH_BITS-1:0] glyph;
    logic [GLYPH_W-1:0]    row_bits;
    logic                  lit;

    always_comb begin
        glyph    = (x_cell < 3'd4) ? active[FB_BITS-1 -: GLYPH_BITS] : active[GLYPH_BITS-1:0];
        row_bits = glyph_row(glyph, y_cell);
        lit      = 1'b0;
        if (x_act && y_act) begin
            case (x_cell)
                3'd0, 3'd4: lit = row_bits[2];
                3'd1, 3'd5: lit = row_bits[1];
                3'd2, 3'd6: lit = row_bits[0];
                default:    lit = 1'b0;
            endcase
        end
    end

    logic pixel_on;

`ifdef GLYPH_SCANOUT_BORDER_EN
    localparam int BX_L = X0 - 1;
    localparam int BX_R = X0 + CELLS_W * SCALE;
    localparam int BY_T = Y0 - 1;
    localparam int BY_B = Y0 + GLYPH_H * SCALE;

    logic on_border;

    always_comb begin
        on_border = 1'b0;
        if ((int'(h_cnt) == BX_L || int'(h_cnt) == BX_R) &&
            int'(v_cnt) >= BY_T && int'(v_cnt) <= BY_B) begin
            on_border = 1'b1;
        end
        if ((int'(v_cnt) == BY_T || int'(v_cnt) == BY_B) &&
            int'(h_cnt) >= BX_L && int'(h_cnt) <= BX_R) begin
            on_border = 1'b1;
        end
    end

    assign pixel_on = lit || on_border;
`else
    assign pixel_on = lit;
`endif

    colour_t colour;
    logic    frame_start;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            colour      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (!visible) begin
                colour <= '0;
            end else if (pixel_on) begin
                colour <= FG;
            end else begin
                colour <= BG;
            end
        end
    end

    assign bus.hsync       = hsync;
    assign bus.vsync       = vsync;
    assign bus.vga_r       = colour[11:8];
    assign bus.vga_g       = colour[7:4];
    assign bus.vga_b       = colour[3:0];
    assign bus.frame_start = frame_start;

endmodule
